// File: rtl/fs_score_sched.sv
// FAST9 score memory sequencer: per-frame zero fill, then
// round-robin sharing of the single SRAM port between writer and reader.
module fs_score_sched #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32768
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              frameStart,
  input  logic              wrValid,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrReady,
  input  logic              rdValid,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              rdReady,
  output logic              rdDataValid,
  output logic [DATA_W-1:0] rdData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memData,
  output logic              memWren,
  input  logic [DATA_W-1:0] memQ,
  output logic              clearing,
  output logic              clearDone,
  output logic [15:0]       cornerCount
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clearPtr;
  logic [ADDR_W-1:0] lastAddr;
  logic              lastWinWr;
  logic              run;
  logic              conflict;
  logic              wrGrant;
  logic              rdGrant;

  always_comb begin
    run      = (state == RUN) && !frameStart;
    conflict = wrValid && rdValid;
    wrGrant  = run && wrValid && (!rdValid || !lastWinWr);
    rdGrant  = run && rdValid && (!wrValid || lastWinWr);
    clearing  = (state == CLEAR);
    clearDone = clearing && (clearPtr == LAST);
    wrReady  = wrGrant;
    rdReady  = rdGrant;
    rdData   = memQ;
    memAddr  = lastAddr;
    memData  = '0;
    memWren  = 1'b0;
    unique case (1'b1)
      clearing: begin
        memAddr = clearPtr;
        memWren = 1'b1;
      end
      wrGrant: begin
        memAddr = wrAddr;
        memData = wrData;
        memWren = 1'b1;
      end
      rdGrant: begin
        memAddr = rdAddr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      clearPtr    <= '0;
      lastAddr    <= '0;
      lastWinWr   <= 1'b0;
      cornerCount <= '0;
      rdDataValid <= 1'b0;
    end else begin
      rdDataValid <= rdGrant;
      lastAddr    <= memAddr;
      if (frameStart) begin
        state       <= CLEAR;
        clearPtr    <= '0;
        cornerCount <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          CLEAR: begin
            if (clearDone) state <= RUN;
            else clearPtr <= clearPtr + 1'b1;
          end
          RUN: begin
            // only a two-way conflict moves the round-robin pointer
            if (conflict) lastWinWr <= wrGrant;
            if (wrGrant && (wrData != '0) &&
                (cornerCount != 16'hFFFF))
              cornerCount <= cornerCount + 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fs_score_sched.sv
// Bench for fs_score_sched: SRAM model, scoreboard of read data,
// clear sweep, arbitration, counter saturation and async reset.
module tb_fs_score_sched;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int DP = 16;

  logic          clock = 1'b0;
  logic          nReset;
  logic          frameStart;
  logic          wrValid;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          wrReady;
  logic          rdValid;
  logic [AW-1:0] rdAddr;
  logic          rdReady;
  logic          rdDataValid;
  logic [DW-1:0] rdData;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic          memWren;
  logic [DW-1:0] memQ;
  logic          clearing;
  logic          clearDone;
  logic [15:0]   cornerCount;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] q [$];
  int errors = 0;
  int checks = 0;
  logic anyRdy;

  fs_score_sched #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clock(clock), .nReset(nReset), .frameStart(frameStart),
    .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData),
    .wrReady(wrReady), .rdValid(rdValid), .rdAddr(rdAddr),
    .rdReady(rdReady), .rdDataValid(rdDataValid), .rdData(rdData),
    .memAddr(memAddr), .memData(memData), .memWren(memWren),
    .memQ(memQ), .clearing(clearing), .clearDone(clearDone),
    .cornerCount(cornerCount)
  );

  always #5 clock = ~clock;

  // garbage left in low addresses on reset so the sweep is visible
  always @(posedge clock) begin
    if (!nReset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hAA;
    end else begin
      if (memWren) mem[memAddr] <= memData;
      memQ <= mem[memAddr];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb();
    if (rdDataValid) begin
      if (q.size() == 0) chk("rd_spurious", 1, 0);
      else chk("rd_data", rdData, q.pop_front());
    end
    chk("ready_excl", {31'd0, wrReady & rdReady}, 0);
    if (rdValid && rdReady) q.push_back(shadow[rdAddr]);
    if (wrValid && wrReady) shadow[wrAddr] = wrData;
  endtask

  task automatic cyc(input logic fs,
                     input logic wv,
                     input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd,
                     input logic rv,
                     input logic [AW-1:0] ra);
    @(posedge clock);
    #1;
    frameStart = fs;
    wrValid = wv;
    wrAddr = wa;
    wrData = wd;
    rdValid = rv;
    rdAddr = ra;
    if (fs) for (int i = 0; i < DP; i++) shadow[i] = '0;
    @(negedge clock);
    sb();
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, 0, '0);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DP; i++) begin
      cyc(0, 1, 15'h1A5, 8'h3C, 0, '0);
      chk({tag, "_addr"}, memAddr, i);
      chk({tag, "_wren"}, memWren, 1);
      chk({tag, "_data"}, memData, 0);
      chk({tag, "_clr"}, clearing, 1);
      chk({tag, "_done"}, clearDone, (i == DP - 1));
      chk({tag, "_wrdy"}, wrReady, 0);
    end
  endtask

  initial begin
    nReset = 1'b0;
    frameStart = 0;
    wrValid = 0;
    wrAddr = '0;
    wrData = '0;
    rdValid = 0;
    rdAddr = '0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    repeat (2) @(posedge clock);
    #1 wrValid = 1; rdValid = 1;
    @(negedge clock);
    chk("rst_wrdy", wrReady, 0);
    chk("rst_rrdy", rdReady, 0);
    chk("rst_rdv", rdDataValid, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_data", memData, 0);
    chk("rst_wren", memWren, 0);
    chk("rst_clr", clearing, 0);
    chk("rst_done", clearDone, 0);
    chk("rst_cnt", cornerCount, 0);
    @(posedge clock);
    #1 nReset = 1'b1;
    @(negedge clock);
    chk("idle_rdy", {wrReady, rdReady}, 0);

    cyc(1, 0, '0, '0, 0, '0);
    chk("fs_clr", clearing, 0);
    chk("fs_wren", memWren, 0);
    sweep("clr1");

    cyc(0, 1, 15'h1A5, 8'h3C, 0, '0);
    chk("w1_rdy", wrReady, 1);
    chk("w1_addr", memAddr, 15'h1A5);
    chk("w1_data", memData, 8'h3C);
    chk("w1_wren", memWren, 1);
    cyc(0, 0, '0, '0, 1, 15'h1A5);
    chk("r1_rdy", rdReady, 1);
    chk("r1_wren", memWren, 0);
    chk("r1_addr", memAddr, 15'h1A5);
    chk("cnt1", cornerCount, 1);
    idle();
    chk("r1_rdv", rdDataValid, 1);
    chk("hold_addr", memAddr, 15'h1A5);
    chk("hold_data", memData, 0);
    chk("hold_wren", memWren, 0);

    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, AW'(15'h010 + i), DW'(8'h11 + i), 1, 15'h1A5);
      chk("rr_w", wrReady, (i % 2 == 0));
      chk("rr_r", rdReady, (i % 2 == 1));
    end
    idle();
    chk("cnt_rr", cornerCount, 4);
    cyc(0, 0, '0, '0, 1, 15'h012);
    idle();

    cyc(0, 0, '0, '0, 1, 15'h010);
    chk("pre_fs_r", rdReady, 1);
    cyc(1, 1, 15'h020, 8'h55, 0, '0);
    chk("fsrun_wrdy", wrReady, 0);
    chk("fsrun_wren", memWren, 0);
    chk("fsrun_rdv", rdDataValid, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 15'h020, 8'h55, 0, '0);
      chk("rs_addr", memAddr, i);
      chk("rs_cnt", cornerCount, 0);
    end
    cyc(1, 1, 15'h020, 8'h55, 0, '0);
    chk("fsclr_wrdy", wrReady, 0);
    chk("fsclr_clr", clearing, 1);
    sweep("clr2");

    cyc(0, 1, 15'h100, 8'h00, 0, '0);
    chk("w0_rdy", wrReady, 1);
    for (int i = 1; i < 4; i++) cyc(0, 1, AW'(15'h100 + i), 8'hFF, 0, '0);
    idle();
    chk("cnt3", cornerCount, 3);
    cyc(0, 0, '0, '0, 1, 15'h003);
    cyc(0, 0, '0, '0, 1, 15'h100);
    cyc(0, 0, '0, '0, 1, 15'h102);
    idle();

    for (int n = 0; n < 65532; n++) cyc(0, 1, 15'h200, 8'h01, 0, '0);
    idle();
    chk("cnt_max", cornerCount, 16'hFFFF);
    cyc(0, 1, 15'h201, 8'h07, 0, '0);
    idle();
    chk("cnt_sat", cornerCount, 16'hFFFF);

    cyc(1, 0, '0, '0, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 15'h1, 8'h1, 0, '0);
    #2 nReset = 1'b0;
    #1;
    chk("arst_clr", clearing, 0);
    chk("arst_wren", memWren, 0);
    chk("arst_addr", memAddr, 0);
    chk("arst_data", memData, 0);
    chk("arst_done", clearDone, 0);
    chk("arst_wrdy", wrReady, 0);
    chk("arst_rdv", rdDataValid, 0);
    q.delete();
    @(posedge clock);
    #1 nReset = 1'b1;
    anyRdy = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 15'h300, 8'h9, 1, 15'h300);
      anyRdy = anyRdy | wrReady | rdReady;
    end
    chk("post_rst_rdy", anyRdy, 0);
    cyc(1, 1, 15'h300, 8'h9, 1, 15'h300);
    anyRdy = 0;
    for (int i = 0; i < DP; i++) begin
      cyc(0, 1, 15'h300, 8'h9, 1, 15'h300);
      anyRdy = anyRdy | wrReady | rdReady;
    end
    chk("sweep_rdy", anyRdy, 0);
    cyc(0, 1, 15'h300, 8'h9, 1, 15'h300);
    chk("first_w", wrReady, 1);
    cyc(0, 0, '0, '0, 1, 15'h300);
    idle();
    chk("sb_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fs_score_sched.md
# fs_score_sched

Sequencer and arbiter for the FAST9 score memory (32K x 8, single port, 15-bit address). It zero-fills the memory at every frame start, then shares the single port between two requesters. The write requester is the score stage, which delivers corner address and score pairs. The read requester is the downstream non-maximum-suppression stage, which fetches neighbour scores. The block sits between the score datapath and the score SRAM and is the only driver of the SRAM's address, data and wren pins.

## Interface
- ADDR_W, 15, score memory address width
- DATA_W, 8, score width
- DEPTH, 32768, number of score locations cleared per frame (≤ 2^ADDR_W)
- clock  in  1  single system clock, rising edge
- nReset  in  1  asynchronous, active-low reset
- frameStart  in  1  one-cycle pulse; starts the clear sweep for a new frame
- wrValid  in  1  score stage has a write pending
- wrAddr  in  ADDR_W  corner (reference pixel) address
- wrData  in  DATA_W  corner score
- wrReady  out  1  write accepted this cycle when wrValid=1
- rdValid  in  1  NMS stage has a read pending
- rdAddr  in  ADDR_W  address to read
- rdReady  out  1  read accepted this cycle when rdValid=1
- rdDataValid  out  1  rdData is valid this cycle
- rdData  out  DATA_W  read score (memQ pass-through)
- memAddr  out  ADDR_W  SRAM address
- memData  out  DATA_W  SRAM write data
- memWren  out  1  SRAM write enable
- memQ  in  DATA_W  SRAM read data, valid the cycle after the address is presented
- clearing  out  1  clear sweep in progress
- clearDone  out  1  one-cycle pulse when the final clear write is issued
- cornerCount  out  16  number of non-zero scores written this frame, saturating at 0xFFFF

## Operation
- States: IDLE, CLEAR, RUN. Reset enters IDLE. IDLE and CLEAR hold wrReady=rdReady=0.
- frameStart from any state enters CLEAR next cycle:
  - clearPtr←0, cornerCount←0.
  - frameStart takes precedence over any request in the same cycle: no grant that cycle.
- CLEAR:
  - Each cycle drives memAddr=clearPtr, memData=0, memWren=1, then clearPtr+1.
  - On the cycle clearPtr==DEPTH-1 the block asserts clearDone and moves to RUN next cycle.
  - clearing=1 for exactly DEPTH cycles.
- RUN, at most one grant per cycle:
  - Only wrValid: grant write. Only rdValid: grant read.
  - Both valid: round-robin. Grant the side not granted at the previous two-way conflict. lastWin resets to "read", so the first conflict goes to the write.
  - Single-requester grants do not update lastWin.
- Write grant:
  - wrReady=1, memAddr=wrAddr, memData=wrData, memWren=1.
  - If wrData≠0, cornerCount increments (saturating).
- Read grant:
  - rdReady=1, memAddr=rdAddr, memWren=0.
  - The next cycle, rdDataValid=1 and rdData=memQ.
- Idle port: memWren=0, memAddr holds its last value, memData=0.
- Ready and mem outputs are combinational from current state and valids. Requesters must not make valid depend on ready.
- A read granted in the cycle before frameStart still returns rdDataValid in the following cycle.
- A write granted in cycle N is visible to a read granted in cycle N+1 or later. Write and read never share a cycle, so there is no collision case.

## Timing
- Reset values: wrReady=0, rdReady=0, rdDataValid=0, rdData=memQ (don't-care while rdDataValid=0), memAddr=0, memData=0, memWren=0, clearing=0, clearDone=0, cornerCount=0; state IDLE, lastWin=read.
- Reset mid-sweep aborts immediately to IDLE. The memory is then not guaranteed zero, so a new frameStart is required.
- frameStart mid-sweep restarts the sweep at address 0.
- Latencies:
  - frameStart to first clear write: 1 cycle.
  - frameStart to first RUN grant: DEPTH+1 cycles.
  - Read grant to rdDataValid: 1 cycle.
- Sustained throughput is 1 transaction/cycle. Under a continuous conflict, writes and reads alternate.
- clearPtr is ADDR_W bits and never wraps past DEPTH-1.

## Test plan
- Reset then frameStart (DEPTH=16 build) -> memWren=1, memData=0 at addresses 0..15 on 16 consecutive cycles; clearDone on address 15; wrReady first possible on cycle 17.
- RUN: write 0x1A5→0x3C, then read 0x1A5 the next cycle -> rdDataValid one cycle after rdReady, rdData=0x3C; cornerCount=1.
- wrValid and rdValid both held high for 6 cycles -> grants W,R,W,R,W,R; no cycle has both ready signals high.
- Writes with wrData=0 and 0xFF ×3 -> cornerCount=3. Force 0xFFFF, one more non-zero write -> cornerCount stays 0xFFFF.
- frameStart asserted together with wrValid mid-RUN, and again mid-CLEAR -> no grant that cycle; clearPtr restarts at 0; cornerCount=0.
- nReset dropped asynchronously mid-CLEAR -> all outputs reach reset values without waiting for a clock edge; state IDLE; readies stay 0 until the next frameStart and full sweep.
